rr_burst_sched: RTL and testbench
=================================

# rr_burst_sched

Burst-level round-robin scheduler that shares one downstream bus among N requesters. It picks a requester with a fair rotating priority and locks the grant for a whole multi-beat burst of a per-requester length. It releases the grant only after the last beat is accepted, then rotates. It sits between the requester ports and the shared bus mux: `grant`/`grant_idx` drive the mux select, and `bus_ready` is the bus-side accept.

## Interface
- `N`, 4: number of requesters, 2..16.
- `LENW`, 4: width of each burst-length field.
- `IW`, `$clog2(N)`: index width (derived, not overridden).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req` input N: level request per requester, bit i = requester i.
- `req_len` input N*LENW: packed burst lengths in beats; field i is `[i*LENW +: LENW]`; value 0 means 1 beat.
- `bus_ready` input 1: downstream accepts the current beat this cycle.
- `grant` output N: registered one-hot grant, or all-zero when idle.
- `grant_idx` output IW: binary index of the granted requester; 0 when idle.
- `busy` output 1: a burst is in progress (`grant != 0`).
- `beat_fire` output 1: `busy & bus_ready`; a beat is transferred this cycle.
- `last` output 1: `beat_fire` on the final beat of the burst.

## Operation
- **States.**
  - IDLE: no grant.
  - BURST: grant locked; `remaining` counter is active, LENW+1 bits wide.
- **Priority pointer.**
  - One-hot, N bits. The bit at position p marks requester p as highest priority; priority descends upward from p with wrap-around.
  - Reset value is 1, so requester 0 has highest priority.
  - After a burst by requester k, the pointer is k rotated left by one: requester k+1 mod N becomes highest and k becomes lowest.
- **Pick (combinational).** `pick = first set bit of req at or above pointer position, wrapping`. Implement it as `{req,req} & ~({req,req} - pointer)`, then OR the upper half with the lower half.
- **IDLE.**
  - If `req != 0`, register `grant <= pick` and `grant_idx <= index(pick)`.
  - Load `remaining <= max(req_len[pick], 1)`, sampled in this same cycle.
  - Go to BURST.
- **BURST.**
  - Each `beat_fire` decrements `remaining`.
  - `last = beat_fire & (remaining == 1)`.
  - When `bus_ready` = 0, all state is held.
- **End of burst (on `last`).**
  - The pointer updates.
  - Re-arbitration uses the updated pointer in the same cycle. If any `req` is set, the new grant and length are registered for the next cycle with no idle bubble; the same requester may win again only if it is the sole requester.
  - If no `req` is set, go to IDLE with `grant` = 0.
- **Request withdrawal mid-burst.** Ignored; the burst runs to completion. `req_len` is not re-sampled during a burst.
- **Reset (also mid-burst).** Immediately `grant` = 0, `grant_idx` = 0, `busy`/`beat_fire`/`last` = 0, state = IDLE, pointer = 1, `remaining` = 0.

## Timing
- Arbitration latency: `req` high in IDLE at cycle t gives `grant` high at t+1. The first beat can fire at t+1.
- Burst of L beats with `bus_ready` held high: grant is held for L cycles, and `last` is in cycle L of the grant.
- Back-to-back bursts: the new grant appears in the cycle after `last`, with 0 dead cycles.
- `beat_fire` and `last` are combinational from registered state and `bus_ready`. There is no combinational path from `req` to any output.
- `remaining` never underflows: a decrement happens only on `beat_fire` when `remaining` ≥ 1.

## Structure
- Package `sched_pkg`:
  - state enum `{S_IDLE, S_BURST}`;
  - default `N` and `LENW` constants;
  - a function converting a one-hot vector to a binary index (all-zero maps to 0).
- Sub-module `rr_pick`:
  - parameter `N`, inputs `req` and `pointer`, output one-hot `pick`;
  - purely combinational, instantiated once.
- Top level holds the FSM, the pointer register, the `remaining` counter and the grant registers.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-burst. Required: `grant` = 0, `grant_idx` = 0, `busy` = `last` = 0 at once. After release with `req` = 1111, the first grant is 0001.
- **Single burst:** `req` = 0100, `req_len[2]` = 3, `bus_ready` = 1. Required: `grant` = 0100 for 3 cycles, `grant_idx` = 2, `last` in the 3rd cycle, `grant` = 0 afterwards.
- **Fair rotation:** `req` = 1111 held, all lengths 1, `bus_ready` = 1. Required: grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles with no bubbles.
- **Backpressure:** `req` = 0010, length 2, `bus_ready` sequence 1,0,0,1. Required: `beat_fire` on cycles 1 and 4 only, `last` on cycle 4, grant held throughout.
- **Length 0 and withdrawal:** `req_len` = 0 gives a 1-beat burst. With `req` = 1000 at length 4, dropping `req` after beat 1 still yields 4 beats and then IDLE.
- **Wrap priority:** after a burst by requester 3, `req` = 1001 grants 0001. After a burst by requester 0, `req` = 1001 grants 1000.

Source files
------------

// File: rtl/rr_burst_sched_pkg.sv
// Shared types and helpers for the burst-level round-robin scheduler.
// Holds the FSM state encoding, default sizing and the one-hot to index helper.
package sched_pkg;

   typedef enum logic {
      S_IDLE,
      S_BURST
   } state_t;

   localparam int unsigned DEF_N    = 4;
   localparam int unsigned DEF_LENW = 4;

   // Binary index of the set bit in a one-hot vector (up to 16 wide); all-zero gives 0.
   function automatic int unsigned onehot_to_idx(input logic [15:0] v);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (v[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above the one-hot pointer,
// wrapping around. Purely combinational.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] pointer,
   output logic [N-1:0] pick
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] masked;

   // Doubling the request vector lets the borrow chain of the subtraction wrap past bit N-1.
   assign dbl    = {req, req};
   assign masked = dbl & ~(dbl - {{N{1'b0}}, pointer});
   assign pick   = masked[N-1:0] | masked[2*N-1:N];

endmodule

// File: rtl/rr_burst_sched.sv
// Burst-level round-robin scheduler: locks a one-hot grant for a whole
// multi-beat burst, then rotates priority and re-arbitrates with no bubble.
module rr_burst_sched
   import sched_pkg::*;
#(
   parameter int unsigned N    = DEF_N,
   parameter int unsigned LENW = DEF_LENW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           req,
   input  logic [N*LENW-1:0]      req_len,
   input  logic                   bus_ready,
   output logic [N-1:0]           grant,
   output logic [$clog2(N)-1:0]   grant_idx,
   output logic                   busy,
   output logic                   beat_fire,
   output logic                   last
);

   localparam int unsigned IW = $clog2(N);
   typedef logic [LENW:0] rem_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [N-1:0]  ptr_q, ptr_d;
   logic [IW-1:0] idx_q, idx_d;
   rem_t          rem_q, rem_d;

   logic [N-1:0]    ptr_rot;
   logic [N-1:0]    ptr_arb;
   logic [N-1:0]    pick;
   logic [LENW-1:0] sel_len;
   rem_t            load_len;

   assign busy      = |grant_q;
   assign beat_fire = busy & bus_ready;
   assign last      = beat_fire & (rem_q == rem_t'(1));

   assign grant     = grant_q;
   assign grant_idx = idx_q;

   // The finishing requester drops to lowest priority; arbitration in the
   // same cycle must already see the rotated pointer.
   assign ptr_rot = {grant_q[N-2:0], grant_q[N-1]};
   assign ptr_arb = last ? ptr_rot : ptr_q;

   rr_pick #(.N(N)) u_pick (
      .req     (req),
      .pointer (ptr_arb),
      .pick    (pick)
   );

   always_comb begin
      sel_len = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pick[i]) sel_len = req_len[i*LENW +: LENW];
      end
      load_len = (sel_len == '0) ? rem_t'(1) : rem_t'(sel_len);
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               grant_d = pick;
               idx_d   = IW'(onehot_to_idx(16'(pick)));
               rem_d   = load_len;
               state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (beat_fire) begin
               rem_d = rem_q - rem_t'(1);
               if (last) begin
                  ptr_d = ptr_rot;
                  if (|req) begin
                     grant_d = pick;
                     idx_d   = IW'(onehot_to_idx(16'(pick)));
                     rem_d   = load_len;
                  end else begin
                     grant_d = '0;
                     idx_d   = '0;
                     rem_d   = '0;
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= N'(1);
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
      end
   end

endmodule

// File: tb/tb_rr_burst_sched.sv
// Directed bench for rr_burst_sched: expected per-cycle outputs are queued as
// stimulus is driven, then popped and checked against the DUT.
module tb_rr_burst_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic        bus_ready;
   logic [3:0]  grant;
   logic [1:0]  grant_idx;
   logic        busy;
   logic        beat_fire;
   logic        last;

   typedef struct {
      string      tag;
      logic [8:0] exp;
   } sb_t;

   sb_t sb_q[$];
   int  tests;
   int  fails;

   rr_burst_sched #(.N(4), .LENW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_len   (req_len),
      .bus_ready (bus_ready),
      .grant     (grant),
      .grant_idx (grant_idx),
      .busy      (busy),
      .beat_fire (beat_fire),
      .last      (last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Queue the expected {grant, idx, busy, beat_fire, last} for the current cycle,
   // check it mid-cycle, then advance to just after the next rising edge.
   task automatic exp_cyc(input string tag, input logic [3:0] g, input logic [1:0] idx,
                          input logic bf, input logic lst);
      sb_t e;
      sb_t got;
      logic [8:0] obs;
      e.tag = tag;
      e.exp = {g, idx, |g, bf, lst};
      sb_q.push_back(e);
      @(negedge clk);
      obs = {grant, grant_idx, busy, beat_fire, last};
      got = sb_q.pop_front();
      tests++;
      assert (obs === got.exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b (grant,idx,busy,fire,last)", got.tag, obs, got.exp);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst_n     = 1'b0;
      req       = '0;
      req_len   = '0;
      bus_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_cyc("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // single burst, requester 2, length 3
      req = 4'b0100; req_len[8 +: 4] = 4'd3; bus_ready = 1'b1;
      exp_cyc("sb_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = '0;
      exp_cyc("sb_beat1", 4'b0100, 2'd2, 1'b1, 1'b0);
      exp_cyc("sb_beat2", 4'b0100, 2'd2, 1'b1, 1'b0);
      exp_cyc("sb_beat3", 4'b0100, 2'd2, 1'b1, 1'b1);
      exp_cyc("sb_after", 4'b0000, 2'd0, 1'b0, 1'b0);

      // wrap priority with length-0 bursts; pointer now favours requester 3
      req_len = '0; req = 4'b1000;
      exp_cyc("wr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = 4'b1001;
      exp_cyc("wr_g3_len0", 4'b1000, 2'd3, 1'b1, 1'b1);
      exp_cyc("wr_after3", 4'b0001, 2'd0, 1'b1, 1'b1);
      req = '0;
      exp_cyc("wr_after0", 4'b1000, 2'd3, 1'b1, 1'b1);
      exp_cyc("wr_idle2", 4'b0000, 2'd0, 1'b0, 1'b0);

      // reset in the middle of a burst
      req = 4'b0100; req_len[8 +: 4] = 4'd4;
      exp_cyc("mr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      exp_cyc("mr_beat1", 4'b0100, 2'd2, 1'b1, 1'b0);
      rst_n = 1'b0;
      exp_cyc("mr_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

      // fair rotation after reset release
      rst_n = 1'b1; req = 4'b1111; req_len = '0;
      exp_cyc("fr_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      exp_cyc("fr_g0", 4'b0001, 2'd0, 1'b1, 1'b1);
      exp_cyc("fr_g1", 4'b0010, 2'd1, 1'b1, 1'b1);
      exp_cyc("fr_g2", 4'b0100, 2'd2, 1'b1, 1'b1);
      exp_cyc("fr_g3", 4'b1000, 2'd3, 1'b1, 1'b1);
      req = '0;
      exp_cyc("fr_g0_again", 4'b0001, 2'd0, 1'b1, 1'b1);
      exp_cyc("fr_after", 4'b0000, 2'd0, 1'b0, 1'b0);

      // backpressure, requester 1, length 2, ready 1,0,0,1
      req = 4'b0010; req_len[4 +: 4] = 4'd2; bus_ready = 1'b1;
      exp_cyc("bp_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      req = '0;
      exp_cyc("bp_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
      bus_ready = 1'b0;
      exp_cyc("bp_c2", 4'b0010, 2'd1, 1'b0, 1'b0);
      exp_cyc("bp_c3", 4'b0010, 2'd1, 1'b0, 1'b0);
      bus_ready = 1'b1;
      exp_cyc("bp_c4", 4'b0010, 2'd1, 1'b1, 1'b1);
      exp_cyc("bp_after", 4'b0000, 2'd0, 1'b0, 1'b0);

      // withdrawal: requester 3, length 4, req dropped after first beat
      req = 4'b1000; req_len[12 +: 4] = 4'd4;
      exp_cyc("wd_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      exp_cyc("wd_beat1", 4'b1000, 2'd3, 1'b1, 1'b0);
      req = '0; req_len = '0;
      exp_cyc("wd_beat2", 4'b1000, 2'd3, 1'b1, 1'b0);
      exp_cyc("wd_beat3", 4'b1000, 2'd3, 1'b1, 1'b0);
      exp_cyc("wd_beat4", 4'b1000, 2'd3, 1'b1, 1'b1);
      exp_cyc("wd_after", 4'b0000, 2'd0, 1'b0, 1'b0);
      exp_cyc("wd_idle_hold", 4'b0000, 2'd0, 1'b0, 1'b0);

      // pointer now favours requester 0; sole requester 2 still wins
      req = 4'b0100; req_len[8 +: 4] = 4'd1;
      exp_cyc("so_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
      exp_cyc("so_g2", 4'b0100, 2'd2, 1'b1, 1'b1);
      req = '0;
      exp_cyc("so_g2_again", 4'b0100, 2'd2, 1'b1, 1'b1);
      exp_cyc("so_after", 4'b0000, 2'd0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
